// File: rtl/comparator_pkg.sv
// Shared definitions for the magnitude-comparator BIST engine: FSM state
// encoding, parameter limits and the golden comparison model.
package comparator_pkg;

  localparam int MAX_WIDTH   = 8;
  localparam int MAX_LATENCY = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } bist_state_t;

  // Golden unsigned comparison, returned as {a<b, a==b, a>b}
  function automatic logic [2:0] cmp_expect(input logic [MAX_WIDTH-1:0] a,
                                            input logic [MAX_WIDTH-1:0] b);
    return {a < b, a == b, a > b};
  endfunction

endpackage

// File: rtl/bist_delay_line.sv
// Delays each driven vector's {valid, a, b, expected} by the comparator's
// pipeline depth so the check lines up with the comparator's response.
// With LATENCY = 0 the entry passes straight through.
module bist_delay_line #(
  parameter int WIDTH   = 2,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_valid,
  input  logic [WIDTH-1:0] entry_a,
  input  logic [WIDTH-1:0] entry_b,
  input  logic [2:0]       entry_exp,
  output logic             delayed_valid,
  output logic [WIDTH-1:0] delayed_a,
  output logic [WIDTH-1:0] delayed_b,
  output logic [2:0]       delayed_exp
);

  localparam int EW = 2*WIDTH + 4;

  logic [EW-1:0] entry;
  logic [EW-1:0] tail;

  assign entry = {entry_valid, entry_a, entry_b, entry_exp};

  if (LATENCY == 0) begin : g_wire
    // Clock and reset have no job when there is nothing to register
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign tail = entry;
  end else begin : g_pipe
    logic [EW-1:0] stage [LATENCY];

    // Shift register; reset flushes every entry so nothing stale gets checked
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
      end else begin
        stage[0] <= entry;
        for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
      end
    end

    assign tail = stage[LATENCY-1];
  end

  assign {delayed_valid, delayed_a, delayed_b, delayed_exp} = tail;

endmodule

// File: rtl/comparator_bist.sv
// Built-in self-test for an N-bit magnitude comparator. Sweeps every
// operand pair (a major, b minor), checks L/E/G against the golden model
// after the comparator's latency, and reports pass, error count and the
// first failing operands.
module comparator_bist
  import comparator_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int LATENCY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  input  logic               dut_l,
  input  logic               dut_e,
  input  logic               dut_g,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int IW = 2*WIDTH;
  localparam int CW = 2*WIDTH + 1;
  localparam logic [IW-1:0] IDX_LAST   = '1;
  localparam logic [2:0]    DRAIN_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  bist_state_t    state;
  logic [IW-1:0]  idx;
  logic [2:0]     drain_cnt;

  logic           run_active;
  logic [2:0]     vec_exp;
  logic           dly_valid;
  logic [WIDTH-1:0] dly_a;
  logic [WIDTH-1:0] dly_b;
  logic [2:0]     dly_exp;
  logic           mismatch;
  logic [CW-1:0]  err_next;

  // The operands are simply the two halves of the registered sweep index
  assign dut_a = idx[IW-1:WIDTH];
  assign dut_b = idx[WIDTH-1:0];

  assign run_active = (state == S_RUN);
  assign vec_exp    = cmp_expect(MAX_WIDTH'(dut_a), MAX_WIDTH'(dut_b));

  bist_delay_line #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk           (clk),
    .rst           (rst),
    .entry_valid   (run_active),
    .entry_a       (dut_a),
    .entry_b       (dut_b),
    .entry_exp     (vec_exp),
    .delayed_valid (dly_valid),
    .delayed_a     (dly_a),
    .delayed_b     (dly_b),
    .delayed_exp   (dly_exp)
  );

  // Any deviation from the expected triple counts, including non-one-hot codes
  assign mismatch = dly_valid && ({dut_l, dut_e, dut_g} != dly_exp);
  assign err_next = err_count + CW'(mismatch);

  // Sweep FSM with registered status outputs and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else begin
      if (mismatch) begin
        err_count <= err_next;
        if (err_count == '0) begin
          fail_a <= dly_a;
          fail_b <= dly_b;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            idx       <= '0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        S_RUN: begin
          if (idx == IDX_LAST) begin
            drain_cnt <= '0;
            if (LATENCY > 0) begin
              state <= S_DRAIN;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_bist.sv
// Self-checking bench for comparator_bist: drives a combinational and a
// two-stage registered comparator model (with selectable faults) and checks
// sweep timing and reported results against a reference model.
module tb_comparator_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_req;
  logic sel;
  int   mode;
  logic [2:0] fault_tbl [16];

  int checks = 0;
  int errors = 0;

  logic       start0, start2;
  logic [1:0] d0_a, d0_b, d2_a, d2_b;
  logic       d0_l, d0_e, d0_g, d2_l, d2_e, d2_g;
  logic       d0_busy, d0_done, d0_pass, d2_busy, d2_done, d2_pass;
  logic [4:0] d0_err, d2_err;
  logic [1:0] d0_fa, d0_fb, d2_fa, d2_fb;

  logic       cur_busy, cur_done, cur_pass;
  logic [4:0] cur_err;
  logic [1:0] cur_fa, cur_fb, cur_a, cur_b;

  assign start0 = start_req & ~sel;
  assign start2 = start_req & sel;

  comparator_bist #(.WIDTH(2), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(d0_a), .dut_b(d0_b), .dut_l(d0_l), .dut_e(d0_e), .dut_g(d0_g),
    .busy(d0_busy), .done(d0_done), .pass(d0_pass), .err_count(d0_err),
    .fail_a(d0_fa), .fail_b(d0_fb)
  );

  comparator_bist #(.WIDTH(2), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .dut_a(d2_a), .dut_b(d2_b), .dut_l(d2_l), .dut_e(d2_e), .dut_g(d2_g),
    .busy(d2_busy), .done(d2_done), .pass(d2_pass), .err_count(d2_err),
    .fail_a(d2_fa), .fail_b(d2_fb)
  );

  assign cur_busy = sel ? d2_busy : d0_busy;
  assign cur_done = sel ? d2_done : d0_done;
  assign cur_pass = sel ? d2_pass : d0_pass;
  assign cur_err  = sel ? d2_err  : d0_err;
  assign cur_fa   = sel ? d2_fa   : d0_fa;
  assign cur_fb   = sel ? d2_fb   : d0_fb;
  assign cur_a    = sel ? d2_a    : d0_a;
  assign cur_b    = sel ? d2_b    : d0_b;

  // Comparator under test: 0 correct, 1 E stuck at 0, 2 L/G swapped, 3 table faults
  function automatic logic [2:0] respond(input int m, input int a, input int b,
                                         input logic [2:0] flt);
    logic l, e, g;
    l = (a < b);
    e = (a == b);
    g = (a > b);
    case (m)
      1:       return {l, 1'b0, g};
      2:       return {g, e, l};
      3:       return {l, e, g} ^ flt;
      default: return {l, e, g};
    endcase
  endfunction

  // Combinational comparator for the LATENCY=0 engine
  always_comb {d0_l, d0_e, d0_g} = respond(mode, int'(d0_a), int'(d0_b), fault_tbl[{d0_a, d0_b}]);

  // Two-stage registered comparator for the LATENCY=2 engine
  logic [2:0] p1, p2;
  always_ff @(posedge clk) begin
    p1 <= respond(mode, int'(d2_a), int'(d2_b), fault_tbl[{d2_a, d2_b}]);
    p2 <= p1;
  end
  assign {d2_l, d2_e, d2_g} = p2;

  // Reference: count vectors 0..nvec-1 whose response differs from a plain compare
  function automatic void model(input int m, input int nvec,
                                output int errs, output int fa, output int fb);
    logic [2:0] golden, got;
    errs = 0; fa = 0; fb = 0;
    for (int k = 0; k < nvec; k++) begin
      int a, b;
      a = k / 4;
      b = k % 4;
      golden = {a < b, a == b, a > b};
      got = respond(m, a, b, fault_tbl[k]);
      if (got != golden) begin
        if (errs == 0) begin fa = a; fb = b; end
        errs++;
      end
    end
  endfunction

  // Pulse start, then observe each cycle until done (bounded)
  task automatic sweep(input int restart_at, output int done_cyc, output int busy_cyc,
                       output int order_errs, output int err_at0, output int done_at0);
    @(negedge clk) start_req = 1'b1;
    @(negedge clk) start_req = 1'b0;
    done_cyc = -1; busy_cyc = 0; order_errs = 0;
    err_at0 = int'(cur_err);
    done_at0 = int'(cur_done);
    for (int k = 0; k < 200; k++) begin
      if (cur_done) begin
        done_cyc = k;
        break;
      end
      if (cur_busy) busy_cyc++;
      if (k < 16 && (int'(cur_a) != k / 4 || int'(cur_b) != k % 4)) order_errs++;
      start_req = (k == restart_at);
      @(negedge clk);
    end
    start_req = 1'b0;
  endtask

  task automatic randomize_faults();
    for (int i = 0; i < 16; i++)
      fault_tbl[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({d0_busy, d0_done, d0_pass} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags0 got %b expected 000", {d0_busy, d0_done, d0_pass});
    end
    checks++;
    if ({d0_err, d0_fa, d0_fb, d0_a, d0_b} !== 13'd0) begin
      errors++; $display("[TB] FAIL reset_data0 got %h expected 0", {d0_err, d0_fa, d0_fb, d0_a, d0_b});
    end
    checks++;
    if ({d2_busy, d2_done, d2_pass, d2_err, d2_fa, d2_fb, d2_a, d2_b} !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_all2 got %h expected 0",
                         {d2_busy, d2_done, d2_pass, d2_err, d2_fa, d2_fb, d2_a, d2_b});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed(input int m, input int exp_err, input int exp_fa, input int exp_fb);
    int dc, bc, oe, e0, d0;
    sel = 1'b0; mode = m;
    sweep(-1, dc, bc, oe, e0, d0);
    checks++;
    if (dc !== 16) begin errors++; $display("[TB] FAIL mode%0d done_cycle got %0d expected 16", m, dc); end
    checks++;
    if (bc !== 16 || cur_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL mode%0d busy got %0d cycles/%b expected 16/0", m, bc, cur_busy);
    end
    checks++;
    if (oe !== 0) begin errors++; $display("[TB] FAIL mode%0d vector_order got %0d bad expected 0", m, oe); end
    checks++;
    if (cur_err !== 5'(exp_err)) begin
      errors++; $display("[TB] FAIL mode%0d err_count got %0d expected %0d", m, cur_err, exp_err);
    end
    checks++;
    if (cur_pass !== (exp_err == 0)) begin
      errors++; $display("[TB] FAIL mode%0d pass got %b expected %b", m, cur_pass, exp_err == 0);
    end
    checks++;
    if (cur_fa !== 2'(exp_fa) || cur_fb !== 2'(exp_fb)) begin
      errors++; $display("[TB] FAIL mode%0d first_fail got %0d,%0d expected %0d,%0d",
                         m, cur_fa, cur_fb, exp_fa, exp_fb);
    end
  endtask

  task automatic test_random_faults(input logic which, input int iters);
    int dc, bc, oe, e0, d0, xe, xa, xb, lat;
    sel = which; mode = 3;
    lat = which ? 2 : 0;
    for (int it = 0; it < iters; it++) begin
      randomize_faults();
      model(3, 16, xe, xa, xb);
      sweep(-1, dc, bc, oe, e0, d0);
      checks++;
      if (dc !== 16 + lat || bc !== 16 + lat) begin
        errors++; $display("[TB] FAIL rand_lat%0d timing done %0d busy %0d expected %0d", lat, dc, bc, 16 + lat);
      end
      checks++;
      if (cur_err !== 5'(xe) || cur_pass !== (xe == 0)) begin
        errors++; $display("[TB] FAIL rand_lat%0d result err %0d pass %b expected %0d %b",
                           lat, cur_err, cur_pass, xe, xe == 0);
      end
      checks++;
      if (cur_fa !== 2'(xa) || cur_fb !== 2'(xb)) begin
        errors++; $display("[TB] FAIL rand_lat%0d first_fail got %0d,%0d expected %0d,%0d",
                           lat, cur_fa, cur_fb, xa, xb);
      end
    end
  endtask

  task automatic test_latency2();
    int dc, bc, oe, e0, d0;
    sel = 1'b1; mode = 0;
    sweep(-1, dc, bc, oe, e0, d0);
    checks++;
    if (dc !== 18 || bc !== 18) begin
      errors++; $display("[TB] FAIL lat2 timing done %0d busy %0d expected 18 18", dc, bc);
    end
    checks++;
    if (cur_pass !== 1'b1 || cur_err !== 5'd0 || oe !== 0) begin
      errors++; $display("[TB] FAIL lat2 result pass %b err %0d order %0d expected 1 0 0", cur_pass, cur_err, oe);
    end
    test_random_faults(1'b1, 2);
  endtask

  task automatic test_start_while_busy();
    int dc, bc, oe, e0, d0;
    sel = 1'b0; mode = 0;
    sweep(5, dc, bc, oe, e0, d0);
    checks++;
    if (dc !== 16 || oe !== 0) begin
      errors++; $display("[TB] FAIL busy_start done %0d order %0d expected 16 0", dc, oe);
    end
    checks++;
    if (cur_pass !== 1'b1) begin errors++; $display("[TB] FAIL busy_start pass got %b expected 1", cur_pass); end
  endtask

  task automatic test_restart_from_done();
    int dc, bc, oe, e0, d0;
    sel = 1'b0; mode = 2;
    sweep(-1, dc, bc, oe, e0, d0);
    sweep(-1, dc, bc, oe, e0, d0);
    checks++;
    if (e0 !== 0 || d0 !== 0) begin
      errors++; $display("[TB] FAIL restart cleared err %0d done %0d expected 0 0", e0, d0);
    end
    checks++;
    if (dc !== 16 || cur_err !== 5'd12) begin
      errors++; $display("[TB] FAIL restart repeat done %0d err %0d expected 16 12", dc, cur_err);
    end
  endtask

  task automatic test_reset_midrun();
    int dc, bc, oe, e0, d0, xe, xa, xb;
    sel = 1'b0; mode = 2;
    model(2, 7, xe, xa, xb);
    @(negedge clk) start_req = 1'b1;
    @(negedge clk) start_req = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (d0_err !== 5'(xe) || d0_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL midrun partial err %0d busy %b expected %0d 1", d0_err, d0_busy, xe);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({d0_busy, d0_done, d0_pass, d0_err, d0_fa, d0_fb, d0_a, d0_b} !== 16'd0) begin
      errors++; $display("[TB] FAIL midrun reset got %h expected 0",
                         {d0_busy, d0_done, d0_pass, d0_err, d0_fa, d0_fb, d0_a, d0_b});
    end
    mode = 0;
    sweep(-1, dc, bc, oe, e0, d0);
    checks++;
    if (dc !== 16 || cur_pass !== 1'b1 || cur_err !== 5'd0) begin
      errors++; $display("[TB] FAIL midrun fresh done %0d pass %b err %0d expected 16 1 0", dc, cur_pass, cur_err);
    end
  endtask

  task automatic test_start_with_rst();
    sel = 1'b0;
    @(negedge clk) begin rst = 1'b1; start_req = 1'b1; end
    @(negedge clk) begin rst = 1'b0; start_req = 1'b0; end
    checks++;
    if (d0_busy !== 1'b0 || d0_done !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_wins busy %b done %b expected 0 0", d0_busy, d0_done);
    end
    @(negedge clk);
    checks++;
    if (d0_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_wins_later busy %b expected 0", d0_busy); end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; start_req = 1'b0; sel = 1'b0; mode = 0;
    for (int i = 0; i < 16; i++) fault_tbl[i] = 3'd0;
    test_reset();
    test_directed(0, 0, 0, 0);
    test_directed(1, 4, 0, 0);
    test_directed(2, 12, 0, 1);
    test_random_faults(1'b0, 4);
    test_start_while_busy();
    test_restart_from_done();
    test_reset_midrun();
    test_start_with_rst();
    test_latency2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
